// File: rtl/id_decode_pipe.sv
// Instruction-decode stage for the zerocpu integer pipeline: decodes OP-IMM/OP/LUI,
// sign-extends immediates, flags illegal words, and registers the bundle behind valid/ready.
module id_decode_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic             ra_en,
    output logic             rb_en,
    output logic [4:0]       ra_addr,
    output logic [4:0]       rb_addr,
    output logic [4:0]       rd_addr,
    output logic             rd_en,
    output logic [XLEN-1:0]  imm,
    output logic             alu_b_src,
    output logic [3:0]       alu_ctl,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_cnt
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctl_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            ra_en;
        logic            rb_en;
        logic            rd_en;
        logic [4:0]      ra_addr;
        logic [4:0]      rb_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] imm;
        logic            alu_b_src;
        alu_ctl_e        alu_ctl;
        logic            illegal;
    } bundle_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            sh_zero;
    logic            sh_sra;
    logic            legal;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    bundle_t         dec;

    logic            out_valid_d, out_valid_q;
    bundle_t         bundle_d, bundle_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign imm_i  = XLEN'($signed(in_inst[31:20]));
    assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));

    // RV64 shifts borrow inst[25] as shamt[5], so only inst[31:26] qualify the shift type.
    always_comb begin
        if (XLEN == 64) begin
            sh_zero = (in_inst[31:26] == 6'b000000);
            sh_sra  = (in_inst[31:26] == 6'b010000);
        end else begin
            sh_zero = (in_inst[31:25] == 7'b0000000);
            sh_sra  = (in_inst[31:25] == 7'b0100000);
        end
    end

    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.ra_addr = in_inst[19:15];
        dec.rb_addr = in_inst[24:20];
        dec.rd_addr = in_inst[11:7];
        dec.alu_ctl = ALU_ADD;
        legal       = 1'b1;

        case (opcode)
            OPC_OP_IMM: begin
                dec.ra_en     = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm       = imm_i;
                case (funct3)
                    3'b000: dec.alu_ctl = ALU_ADD;
                    3'b001: begin
                        dec.alu_ctl = ALU_SLL;
                        legal       = sh_zero;
                    end
                    3'b010: dec.alu_ctl = ALU_SLT;
                    3'b011: dec.alu_ctl = ALU_SLTU;
                    3'b100: dec.alu_ctl = ALU_XOR;
                    3'b101: begin
                        if (sh_zero)     dec.alu_ctl = ALU_SRL;
                        else if (sh_sra) dec.alu_ctl = ALU_SRA;
                        else             legal       = 1'b0;
                    end
                    3'b110: dec.alu_ctl = ALU_OR;
                    3'b111: dec.alu_ctl = ALU_AND;
                endcase
            end
            OPC_OP: begin
                dec.ra_en = 1'b1;
                dec.rb_en = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: dec.alu_ctl = ALU_ADD;
                        3'b001: dec.alu_ctl = ALU_SLL;
                        3'b010: dec.alu_ctl = ALU_SLT;
                        3'b011: dec.alu_ctl = ALU_SLTU;
                        3'b100: dec.alu_ctl = ALU_XOR;
                        3'b101: dec.alu_ctl = ALU_SRL;
                        3'b110: dec.alu_ctl = ALU_OR;
                        3'b111: dec.alu_ctl = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.alu_ctl = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.alu_ctl = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec.alu_b_src = 1'b1;
                dec.alu_ctl   = ALU_PASSB;
                dec.imm       = imm_u;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.ra_en     = 1'b0;
            dec.rb_en     = 1'b0;
            dec.imm       = '0;
            dec.alu_b_src = 1'b0;
            dec.alu_ctl   = ALU_ADD;
        end
        dec.illegal = !legal;
        dec.rd_en   = legal && (dec.rd_addr != 5'd0);
    end

    assign in_ready = !flush && (!out_valid_q || out_ready);

    // Flush wins over both accept and drain; a flushed drain is not counted.
    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        cnt_d       = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready && !flush) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = bundle_q.pc;
    assign ra_en     = bundle_q.ra_en;
    assign rb_en     = bundle_q.rb_en;
    assign rd_en     = bundle_q.rd_en;
    assign ra_addr   = bundle_q.ra_addr;
    assign rb_addr   = bundle_q.rb_addr;
    assign rd_addr   = bundle_q.rd_addr;
    assign imm       = bundle_q.imm;
    assign alu_b_src = bundle_q.alu_b_src;
    assign alu_ctl   = bundle_q.alu_ctl;
    assign illegal   = bundle_q.illegal;
    assign dec_cnt   = cnt_q;

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Registered, parametrised instruction-decode stage for the zerocpu integer pipeline, sitting between the fetch stage and the execute/regfile read stage. It decodes the full RV integer ALU subset (OP-IMM, OP, LUI) instead of ADDI alone. It sign-extends immediates and flags illegal encodings. Results are held in an output register behind a valid/ready handshake, with flush support and a decoded-instruction counter.

## Interface
- `XLEN`, default 64: datapath width; legal values are 32 and 64 (sets the immediate width and the shamt field).
- `CNT_W`, default 32: width of the decoded-instruction counter.
- `clock`, input, 1: single clock; everything changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `in_valid`, input, 1: `in_inst`/`in_pc` are valid.
- `in_ready`, output, 1: the stage can accept; equals `!flush && (!out_valid || out_ready)`.
- `in_inst`, input, 32: instruction word.
- `in_pc`, input, XLEN: PC of `in_inst`; passed through.
- `flush`, input, 1: discard the held and the incoming instruction.
- `out_valid`, output, 1: decoded bundle valid.
- `out_ready`, input, 1: downstream accepts the bundle.
- `out_pc`, output, XLEN: registered PC.
- `ra_en`, `rb_en`, output, 1 each: rs1/rs2 read enables.
- `ra_addr`, `rb_addr`, `rd_addr`, output, 5 each: `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `rd_en`, output, 1: writeback enable.
- `imm`, output, XLEN: sign-extended immediate.
- `alu_b_src`, output, 1: 1 selects `imm` as ALU operand B; 0 selects rs2.
- `alu_ctl`, output, 4: ALU operation code.
- `illegal`, output, 1: encoding is not in the supported subset.
- `dec_cnt`, output, CNT_W: count of output handshakes.

## Operation
- `alu_ctl` encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI).
  - 11–15 are unused.
- OP-IMM (`0010011`):
  - funct3 000/010/011/100/110/111 → ADD/SLT/SLTU/XOR/OR/AND.
  - 001 → SLL, requires the upper funct bits to be 0.
  - 101 → SRL when upper bits are 0; SRA when upper bits are `0100000` (XLEN=32) or `010000` (XLEN=64). Any other upper bits are illegal.
  - Upper funct bits are `inst[31:25]` for XLEN=32 and `inst[31:26]` for XLEN=64.
  - `ra_en`=1, `rb_en`=0, `alu_b_src`=1, `imm` = sext(`inst[31:20]`).
- OP (`0110011`):
  - funct7 `0000000` with funct3 0–7 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 `0100000` with funct3 000 → SUB; with funct3 101 → SRA.
  - Any other combination is illegal.
  - `ra_en`=`rb_en`=1, `alu_b_src`=0, `imm`=0.
- LUI (`0110111`): `ra_en`=`rb_en`=0, `alu_b_src`=1, `alu_ctl`=10, `imm` = sext({`inst[31:12]`, 12'b0}).
- `rd_en` = legal && (`rd_addr` != 0).
- Illegal encodings: `illegal`=1; `ra_en`=`rb_en`=`rd_en`=0; `alu_ctl`=0; `imm`=0. The bundle still flows and still counts.
- Pipeline register:
  - On `in_valid && in_ready`, decode results and `in_pc` are registered and `out_valid` is set.
  - Else on `out_valid && out_ready`, `out_valid` is cleared.
  - While `out_valid && !out_ready`, all outputs hold stable.
- Flush:
  - `flush`=1 clears `out_valid` at the next edge and forces `in_ready`=0, so the same-cycle input is dropped.
  - Flush has priority over the handshake. The dropped bundle is not counted.
- `dec_cnt` increments on `out_valid && out_ready && !flush` and wraps modulo 2^CNT_W.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput: 1 per cycle when `out_ready` is held at 1. Accept and drain in the same cycle is allowed.
- Reset: asserting `reset` immediately clears all outputs and registers to 0 (`out_valid`=0, `dec_cnt`=0), including mid-stall. With reset at 0, `in_ready` = 1 and is combinational.
- Outputs other than `in_ready` are register outputs. No combinational path runs from `in_inst` to any output.

## Test plan
- ADDI x1,x0,-1 (`0xFFF00093`), `out_ready`=1:
  - Next cycle: `out_valid`=1, `ra_en`=1, `rb_en`=0, `rd_en`=1, `rd_addr`=1, `alu_ctl`=0, `alu_b_src`=1.
  - `imm`=`0xFFFFFFFFFFFFFFFF`; `dec_cnt` becomes 1.
- ADD x3,x1,x2 (`0x002081B3`) then SUB (`0x402081B3`) back-to-back:
  - `alu_ctl` = 0 then 1; `ra_en`=`rb_en`=1, `imm`=0, `in_ready` stays 1.
- SRAI x5,x6,63 (`0x43F35293`), XLEN=64 → `alu_ctl`=7, `imm[5:0]`=63, `illegal`=0.
- LUI x7,0x80000 (`0x800003B7`):
  - `alu_ctl`=10, `imm`=`0xFFFFFFFF80000000`, `ra_en`=`rb_en`=0.
  - Word `0x00000000` → `illegal`=1, `rd_en`=0.
- Stall/flush/reset:
  - Hold `out_ready`=0 for 3 cycles: outputs are stable and `in_ready`=0.
  - Assert `flush` alongside a new `in_valid`: `out_valid`=0 next cycle and `dec_cnt` is unchanged.
  - Assert `reset` mid-stall: all outputs are 0 without waiting for a clock edge.
- With `CNT_W`=4, drain 17 instructions → `dec_cnt`=1 (wrap).
